// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: op encodings and handshake FSM state type for seq_alu.
package seq_alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: iterative shift-add multiply / restoring divide, WIDTH steps per operation.
module seq_alu_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH + 1);
  logic             run, div_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] x, y, z, x_d, y_d, z_d;
  logic [WIDTH:0]   sh, diff;
  // x: product accumulator or partial remainder; y: multiplicand or quotient; z: multiplier or divisor
  assign sh     = {x, y[WIDTH-1]};
  assign diff   = sh - {1'b0, z};
  assign x_d    = div_q ? (diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]) : x + (z[0] ? y : '0);
  assign y_d    = div_q ? WIDTH'({y, ~diff[WIDTH]}) : y << 1;
  assign z_d    = div_q ? z : z >> 1;
  assign done   = run && cnt == CW'(WIDTH - 1);
  assign result = div_q ? y_d : x_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run   <= 1'b0;
      div_q <= 1'b0;
      cnt   <= '0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
    end else if (start) begin
      run   <= 1'b1;
      div_q <= is_div;
      cnt   <= '0;
      x     <= '0;
      y     <= a;
      z     <= b;
    end else if (run) begin
      run <= !done;
      cnt <= cnt + CW'(1);
      x   <= x_d;
      y   <= y_d;
      z   <= z_d;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked sequential ALU (add/sub/mul/div); define SEQ_ALU_ERR_EN to add the
// divide-by-zero err output.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef SEQ_ALU_ERR_EN
  ,
  output logic             err
`endif
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_d, iter_res;
  logic [1:0]       op_q;
  logic             accept, iter_start, iter_done, div0, fin;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign accept    = in_valid && in_ready;
  // divide-by-zero never starts the iterator and finishes in a single EXEC cycle
  assign iter_start = accept && op[1] && !(op == OP_DIV && b == '0);
  assign div0       = op_q == OP_DIV && b_q == '0;
  assign fin        = state_q == EXEC && (!op_q[1] || div0 || iter_done);
  assign res_d      = op_q == OP_ADD ? a_q + b_q : op_q == OP_SUB ? a_q - b_q : div0 ? '1 : iter_res;
  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (iter_start),
    .is_div(op[0]),
    .a     (a),
    .b     (b),
    .done  (iter_done),
    .result(iter_res)
  );
  always_comb begin
    state_d = state_q;
    if (accept) state_d = EXEC;
    else if (fin) state_d = DONE;
    else if (out_valid && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      result  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
      end
      if (fin) result <= res_d;
    end
  end
`ifdef SEQ_ALU_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (fin) err <= div0;
  end
`endif
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the command on a/b/op is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a command.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port op, input, 2 bits: 00 = A+B, 01 = A-B, 10 = A*B, 11 = A/B.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port result, output, WIDTH bits: operation result.
REQ-012 The block SHALL have port err, output, 1 bit, present only with SEQ_ALU_ERR_EN: divide-by-zero flag, qualified by out_valid.

Function
REQ-013 The block SHALL accept a command on a rising edge where in_valid && in_ready, capturing a, b and op.
REQ-014 The FSM SHALL have states IDLE, EXEC and DONE.
REQ-015 The FSM SHALL move IDLE->EXEC on accept, EXEC->DONE when the operation completes, and DONE->IDLE on out_valid && out_ready.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 ADD and SUB SHALL complete in one EXEC cycle, so out_valid rises 2 cycles after the accept edge.
REQ-018 MUL SHALL be shift-add and DIV restoring division, each taking exactly WIDTH EXEC cycles, so out_valid rises WIDTH+1 cycles after accept.
REQ-019 All results SHALL be modulo 2^WIDTH (low WIDTH bits): ADD/SUB wrap; MUL keeps the low half of the product; DIV gives the unsigned quotient, remainder discarded.
REQ-020 DIV with b == 0 SHALL skip iteration, complete in one EXEC cycle and return all-ones.
REQ-021 result (and err) SHALL stay stable while out_valid = 1 and out_ready = 0, with no limit on stall length.
REQ-022 in_valid outside IDLE SHALL be ignored, with no state change.
REQ-023 After a result handshake, the earliest next accept SHALL be the following cycle (IDLE).
REQ-024 The operands and op SHALL be sampled only at the accept edge; later input changes SHALL not affect the result.

Reset
REQ-025 While rst = 1, the FSM SHALL be IDLE; in_ready = 1 and out_valid = 0; result, err, the iteration counter and the datapath registers SHALL be 0.
REQ-026 Reset asserted in EXEC or DONE SHALL abort the operation immediately, and no result SHALL be presented after release.

Configuration
REQ-027 With macro SEQ_ALU_ERR_EN defined, port err SHALL exist and equal 1 with a divide-by-zero result, 0 otherwise.
REQ-028 Without SEQ_ALU_ERR_EN, err SHALL be absent and divide-by-zero SHALL return all-ones with no indication.

Structure
REQ-029 Package seq_alu_pkg SHALL hold the op encoding constants OP_ADD, OP_SUB, OP_MUL and OP_DIV and the FSM state type.
REQ-030 The iterative MUL/DIV datapath SHALL be sub-module seq_alu_iter, with start/done, operands in and result out.
REQ-031 seq_alu SHALL own the handshake FSM and the ADD/SUB logic.

Verification
REQ-032 ADD: a=0A, b=02, op=00 -> result=0C, out_valid 2 cycles after accept.
REQ-033 SUB: a=F6, b=0A -> EC; and a=02, b=03 -> FF (wrap).
REQ-034 MUL: a=0F, b=03 -> 2D, out_valid 9 cycles after accept (WIDTH=8); and a=10, b=10 -> 00 (truncated).
REQ-035 DIV: a=1E, b=04 -> 07 in 9 cycles; a=1E, b=00 -> FF in 2 cycles, with err=1 when SEQ_ALU_ERR_EN.
REQ-036 Backpressure and input isolation: out_ready=0 for 5 cycles -> result held, in_ready=0, and in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-037 Reset mid-MUL (cycle 4 of EXEC): rst pulse -> out_valid stays 0, in_ready=1 after release, and the next command gives a correct result.
